// File: rtl/ula_pkg.sv
// ula_pkg: opcode constants, controller state type and flag bundle shared by the ula_mc files.
package ula_pkg;
    localparam int OP_ADD = 3;
    localparam int OP_SUB = 4;
    localparam int OP_MUL = 5;
    localparam int OP_DIV = 6;
    localparam int OP_AND = 7;
    localparam int OP_OR  = 8;
    localparam int OP_SHL = 9;
    localparam int OP_SHR = 10;
    localparam int OP_CMP = 11;
    localparam int OP_NOT = 12;

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    typedef struct packed {
        logic eq;
        logic ab;
        logic be;
        logic ov;
        logic er;
    } flags_t;
endpackage

// File: rtl/ula_mc_iter.sv
// ula_mc_iter: WIDTH-step shift-add multiplier / restoring divider; done_o marks the final step,
// lo_o/hi_o carry that step's product low/high (MUL) or quotient/remainder (DIV).
module ula_mc_iter #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start_i,
    input  logic             div_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    output logic             done_o,
    output logic [WIDTH-1:0] lo_o,
    output logic [WIDTH-1:0] hi_o
);
    localparam int CW = $clog2(WIDTH) + 1;

    logic [WIDTH-1:0] lo_q, hi_q, b_q, lo_d, hi_d;
    logic [CW-1:0]    cnt_q;
    logic             busy_q, div_q;
    logic [WIDTH:0]   sum, rem, diff;
    logic             ge;

    always_comb begin
        sum  = {1'b0, hi_q} + (lo_q[0] ? {1'b0, b_q} : '0);
        rem  = {hi_q, lo_q[WIDTH-1]};
        ge   = rem >= {1'b0, b_q};
        diff = ge ? rem - {1'b0, b_q} : rem;
        hi_d = div_q ? diff[WIDTH-1:0] : sum[WIDTH:1];
        lo_d = div_q ? {lo_q[WIDTH-2:0], ge} : {sum[0], lo_q[WIDTH-1:1]};
    end

    assign done_o = busy_q && (cnt_q == CW'(WIDTH - 1));
    assign lo_o   = lo_d;
    assign hi_o   = hi_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lo_q   <= '0;
            hi_q   <= '0;
            b_q    <= '0;
            cnt_q  <= '0;
            busy_q <= 1'b0;
            div_q  <= 1'b0;
        end else if (start_i) begin
            lo_q   <= a_i;
            hi_q   <= '0;
            b_q    <= b_i;
            cnt_q  <= '0;
            busy_q <= 1'b1;
            div_q  <= div_i;
        end else if (busy_q) begin
            lo_q   <= lo_d;
            hi_q   <= hi_d;
            cnt_q  <= cnt_q + CW'(1);
            busy_q <= !done_o;
        end
    end
endmodule

// File: rtl/ula_mc.sv
// ula_mc: handshaked multi-cycle ALU; MUL/DIV are iterative only when ULA_MC_MULDIV_EN is defined,
// otherwise they report as unknown opcodes.
module ula_mc
    import ula_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int OPC_W = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [OPC_W-1:0] opcode,
    input  logic [WIDTH-1:0] operand_a,
    input  logic [WIDTH-1:0] operand_b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             equal,
    output logic             above,
    output logic             below,
    output logic             overflow,
    output logic             error
);
    state_t           state_q, state_d;
    logic [WIDTH-1:0] result_q, result_d, sc_res;
    flags_t           flags_q, flags_d, sc_flg;
    logic [WIDTH:0]   add_s;
    logic             go_calc, accept, iter_done, sh_big;

    assign accept = in_valid && (state_q == IDLE);
    assign sh_big = operand_b >= WIDTH'(WIDTH);

    // Single-cycle results are computed straight from the accepted inputs.
    always_comb begin
        sc_res  = '0;
        sc_flg  = '0;
        go_calc = 1'b0;
        add_s   = {1'b0, operand_a} + {1'b0, operand_b};
        case (opcode)
            OPC_W'(OP_ADD): begin
                sc_res    = add_s[WIDTH-1:0];
                sc_flg.ov = add_s[WIDTH];
            end
            OPC_W'(OP_SUB): begin
                sc_res    = operand_a - operand_b;
                sc_flg.ov = operand_a < operand_b;
            end
            OPC_W'(OP_AND): sc_res = operand_a & operand_b;
            OPC_W'(OP_OR):  sc_res = operand_a | operand_b;
            OPC_W'(OP_SHL): sc_res = sh_big ? '0 : operand_a << operand_b;
            OPC_W'(OP_SHR): sc_res = sh_big ? '0 : operand_a >> operand_b;
            OPC_W'(OP_NOT): sc_res = ~operand_a;
            OPC_W'(OP_CMP): begin
                sc_flg.eq = operand_a == operand_b;
                sc_flg.ab = operand_a > operand_b;
                sc_flg.be = operand_a < operand_b;
            end
`ifdef ULA_MC_MULDIV_EN
            OPC_W'(OP_MUL): go_calc = 1'b1;
            OPC_W'(OP_DIV): begin
                go_calc   = operand_b != '0;
                sc_flg.er = operand_b == '0;
            end
`endif
            default: sc_flg.er = 1'b1;
        endcase
    end

`ifdef ULA_MC_MULDIV_EN
    logic [WIDTH-1:0] iter_lo, iter_hi;
    logic             div_q;

    ula_mc_iter #(.WIDTH(WIDTH)) u_iter (
        .clk     (clk),
        .rst_n   (rst_n),
        .start_i (accept && go_calc),
        .div_i   (opcode == OPC_W'(OP_DIV)),
        .a_i     (operand_a),
        .b_i     (operand_b),
        .done_o  (iter_done),
        .lo_o    (iter_lo),
        .hi_o    (iter_hi)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) div_q <= 1'b0;
        else if (accept) div_q <= opcode == OPC_W'(OP_DIV);
    end

    always_comb begin
        result_d = result_q;
        flags_d  = flags_q;
        if (accept && !go_calc) begin
            result_d = sc_res;
            flags_d  = sc_flg;
        end else if (state_q == CALC && iter_done) begin
            result_d   = iter_lo;
            flags_d    = '0;
            flags_d.ov = !div_q && (iter_hi != '0);
        end
    end
`else
    assign iter_done = 1'b0;

    always_comb begin
        result_d = accept ? sc_res : result_q;
        flags_d  = accept ? sc_flg : flags_q;
    end
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            result_q <= '0;
            flags_q  <= '0;
        end else begin
            state_q  <= state_d;
            result_q <= result_d;
            flags_q  <= flags_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    state_d = in_valid ? (go_calc ? CALC : DONE) : IDLE;
            CALC:    state_d = iter_done ? DONE : CALC;
            DONE:    state_d = out_ready ? IDLE : DONE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        in_ready  = state_q == IDLE;
        out_valid = state_q == DONE;
        result    = result_q;
        equal     = flags_q.eq;
        above     = flags_q.ab;
        below     = flags_q.be;
        overflow  = flags_q.ov;
        error     = flags_q.er;
    end
endmodule

// File: doc/ula_mc.md
ULA_MC -- requirements
Module: ula_mc

Interface
REQ-001 SHALL have parameter WIDTH, default 32, operand/result width (legal 8..64, power of two).
REQ-002 SHALL have parameter OPC_W, default 5, opcode width.
REQ-003 SHALL have port clk  input  1  sole clock, rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port in_valid  input  1  request present.
REQ-006 SHALL have port in_ready  output  1  request accepted when in_valid&&in_ready.
REQ-007 SHALL have port opcode  input  OPC_W  operation select.
REQ-008 SHALL have ports operand_a, operand_b  input  WIDTH  unsigned operands.
REQ-009 SHALL have port out_valid  output  1  result present.
REQ-010 SHALL have port out_ready  input  1  consumer accepts when out_valid&&out_ready.
REQ-011 SHALL have port result  output  WIDTH  registered result.
REQ-012 SHALL have ports equal, above, below, overflow, error  output  1 each  registered flags.

Function
REQ-013 Opcodes SHALL be ADD=3, SUB=4, MUL=5, DIV=6, AND=7, OR=8, SHL=9, SHR=10, CMP=11, NOT=12; all others unknown.
REQ-014 FSM states SHALL be IDLE, CALC, DONE; in_ready=1 only in IDLE.
REQ-015 IDLE, accept of single-cycle op (all except MUL/DIV, incl. unknown) -> DONE next edge; latency 1 cycle.
REQ-016 IDLE, accept of MUL or DIV with operand_b!=0 -> CALC; exactly WIDTH cycles in CALC, then DONE; latency WIDTH+1.
REQ-017 DIV with operand_b==0 SHALL skip CALC: result=0, error=1, latency 1.
REQ-018 DONE: out_valid=1; result and flags held stable until out_ready; on handshake -> IDLE; no new accept in the same cycle.
REQ-019 Operands and opcode SHALL be captured at accept; later input changes have no effect.
REQ-020 ADD: overflow=carry out of bit WIDTH-1. SUB: overflow=borrow (operand_a<operand_b).
REQ-021 MUL: shift-add, result=low WIDTH bits, overflow=1 iff high WIDTH bits nonzero.
REQ-022 DIV: restoring, result=quotient, overflow=0.
REQ-023 SHL/SHR logical; operand_b>=WIDTH SHALL give result=0.
REQ-024 NOT: result=~operand_a. CMP: result=0, exactly one of equal/above/below set.
REQ-025 Unknown opcode: result=0, error=1.
REQ-026 Flags not defined for the op SHALL be 0.

Reset
REQ-027 rst_n low SHALL immediately force IDLE, out_valid=0, result=0, all flags=0, in_ready=1 after release.
REQ-028 Reset during CALC or DONE SHALL discard the operation; no result emitted.

Configuration
REQ-029 Macro ULA_MC_MULDIV_EN defined: MUL/DIV per REQ-016..022.
REQ-030 Macro ULA_MC_MULDIV_EN undefined: MUL/DIV treated as unknown opcode (REQ-025); CALC state and iterative datapath absent.

Structure
REQ-031 Package ula_pkg SHALL hold opcode constants and the state type.
REQ-032 Iterative MUL/DIV datapath SHALL be sub-module ula_mc_iter (start, op, operands -> done, quotient/product, high half).

Verification (WIDTH=32)
REQ-033 ADD 0xFFFFFFFF+1 -> result 0, overflow=1, out_valid one cycle after accept.
REQ-034 MUL 0x10000*0x10000 -> result 0, overflow=1, out_valid 33 cycles after accept; DIV 100/7 -> 14, overflow=0.
REQ-035 DIV 5/0 -> result 0, error=1, latency 1; opcode 31 -> result 0, error=1.
REQ-036 CMP 7,9 -> below=1 only; SHL 1 by 32 -> 0; SHR 0x80000000 by 31 -> 1.
REQ-037 out_ready low 10 cycles in DONE -> result/flags stable, in_ready=0; new in_valid ignored until handshake.
REQ-038 rst_n low mid-CALC of DIV -> out_valid=0 immediately, next ADD 2+3 -> 5 normally.
